// File: rtl/int_ctrl.sv
// Six-source nesting interrupt controller feeding CP0 HWInt.
// Latches level/edge requests, masks them, and forwards only sources above the in-service threshold.
module int_ctrl #(
  parameter int unsigned N = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  irq_in,
  input  logic [1:0]    addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  input  logic          int_ack,
  output logic [N-1:0]  hwint,
  output logic [2:0]    irq_id
);

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;
  localparam logic [2:0] ID_NONE   = 3'd7;

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] isr_q, isr_d;
  logic [N-1:0] prev_q;
  logic [N-1:0] hwint_q, hwint_d;

  logic [N-1:0] isr_top_oh;
  logic [N-1:0] above_thr;
  logic [N-1:0] w1c;
  logic [N-1:0] mode_chg;
  logic [N-1:0] ack_oh;
  logic [N-1:0] pend_edge;
  logic         seen;
  logic         eoi;
  logic         ack_valid;
  logic         unused_wdata;

  assign unused_wdata = ^wdata[31:N];
  assign hwint        = hwint_q;

  // Priority decode of the registered request vector.
  always_comb begin
    irq_id = ID_NONE;
    for (int i = 0; i < int'(N); i++) begin
      if (hwint_q[i]) irq_id = 3'(i);
    end
  end

  // Highest in-service bit, and the set of sources strictly above it.
  always_comb begin
    isr_top_oh = '0;
    above_thr  = '0;
    seen       = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (isr_q[i]) isr_top_oh = N'(1) << i;
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      seen         = seen | isr_q[i];
      above_thr[i] = ~seen;
    end
  end

  // Next-state for all registers; writes and ack both see pre-edge state.
  always_comb begin
    eoi       = we && (addr == ADDR_ISR);
    w1c       = (we && (addr == ADDR_PEND)) ? wdata[N-1:0] : '0;
    mode_chg  = (we && (addr == ADDR_MODE)) ? (wdata[N-1:0] ^ mode_q) : '0;
    ack_valid = int_ack && (irq_id != ID_NONE);
    ack_oh    = ack_valid ? (N'(1) << irq_id) : '0;

    // Edge set wins over W1C/ack clear; a mode change clears regardless.
    pend_edge = (irq_in & ~prev_q) | (pend_q & ~(w1c | ack_oh));
    pend_d    = ((mode_q & pend_edge) | (~mode_q & irq_in)) & ~mode_chg;

    mask_d  = (we && (addr == ADDR_MASK)) ? wdata[N-1:0] : mask_q;
    mode_d  = (we && (addr == ADDR_MODE)) ? wdata[N-1:0] : mode_q;
    isr_d   = (eoi ? (isr_q & ~isr_top_oh) : isr_q) | ack_oh;
    hwint_d = pend_q & mask_q & above_thr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      isr_q   <= '0;
      prev_q  <= '0;
      hwint_q <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      prev_q  <= irq_in;
      hwint_q <= hwint_d;
    end
  end

  // Register read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PEND: rdata = 32'(pend_q);
      ADDR_MASK: rdata = 32'(mask_q);
      ADDR_MODE: rdata = 32'(mode_q);
      ADDR_ISR:  rdata = {21'd0, irq_id, 2'd0, 6'(isr_q)};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: level/edge latching, nesting, same-cycle corner cases, reset.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [5:0]  hwint;
  logic [2:0]  irq_id;

  int checks   = 0;
  int failures = 0;

  int_ctrl #(.N(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .int_ack(int_ack),
    .hwint  (hwint),
    .irq_id (irq_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_in = '0; addr = '0; we = 1'b0; wdata = '0; int_ack = 1'b0;
    step(); step();
    reset = 1'b1;
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL reset_hwint got %h want 00", hwint); end
    checks++; if (irq_id !== 3'd7) begin failures++; $display("FAIL reset_irq_id got %0d want 7", irq_id); end
    for (int r = 0; r < 3; r++) begin
      addr = 2'(r); #1;
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got %h want 0", r, rdata); end
    end
    addr = 2'd3; #1;
    checks++; if (rdata !== 32'h700) begin failures++; $display("FAIL reset_isr_read got %h want 00000700", rdata); end
  endtask

  task automatic test_level();
    wr(2'd1, 32'h3F);
    irq_in = 6'h04;
    step();
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL level_latency got %h want 00", hwint); end
    step();
    checks++; if (hwint !== 6'h04) begin failures++; $display("FAIL level_hwint got %h want 04", hwint); end
    checks++; if (irq_id !== 3'd2) begin failures++; $display("FAIL level_irq_id got %0d want 2", irq_id); end
    irq_in = 6'h00;
    step(); step();
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL level_drop got %h want 00", hwint); end
  endtask

  task automatic test_edge();
    wr(2'd2, 32'h01);
    wr(2'd1, 32'h01);
    irq_in = 6'h01;
    step();
    irq_in = 6'h00;
    step(); step();
    addr = 2'd0; #1;
    checks++; if (rdata !== 32'h01) begin failures++; $display("FAIL edge_pend_hold got %h want 01", rdata); end
    checks++; if (hwint !== 6'h01) begin failures++; $display("FAIL edge_hwint got %h want 01", hwint); end
    wr(2'd0, 32'h01);
    addr = 2'd0; #1;
    checks++; if (rdata !== 32'h00) begin failures++; $display("FAIL edge_w1c got %h want 00", rdata); end
    step();
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL edge_w1c_hwint got %h want 00", hwint); end
    wr(2'd2, 32'h00);
  endtask

  task automatic test_nesting();
    wr(2'd1, 32'h3F);
    irq_in = 6'h12;
    step(); step();
    checks++; if (irq_id !== 3'd4) begin failures++; $display("FAIL nest_first_id got %0d want 4", irq_id); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    addr = 2'd3; #1;
    checks++; if (rdata[5:0] !== 6'h10) begin failures++; $display("FAIL nest_isr_ack1 got %h want 10", rdata[5:0]); end
    step();
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL nest_masked got %h want 00", hwint); end
    irq_in = 6'h32;
    step(); step();
    checks++; if (hwint !== 6'h20) begin failures++; $display("FAIL nest_src5 got %h want 20", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    addr = 2'd3; #1;
    checks++; if (rdata !== 32'h530) begin failures++; $display("FAIL nest_isr_ack2 got %h want 00000530", rdata); end
    irq_in = 6'h02;
    step();
    wr(2'd3, 32'hFFFF_FFFF);
    addr = 2'd3; #1;
    checks++; if (rdata[5:0] !== 6'h10) begin failures++; $display("FAIL nest_eoi1 got %h want 10", rdata[5:0]); end
    wr(2'd3, 32'h0);
    addr = 2'd3; #1;
    checks++; if (rdata[5:0] !== 6'h00) begin failures++; $display("FAIL nest_eoi2 got %h want 00", rdata[5:0]); end
    step();
    checks++; if (hwint !== 6'h02) begin failures++; $display("FAIL nest_resume got %h want 02", hwint); end
    checks++; if (irq_id !== 3'd1) begin failures++; $display("FAIL nest_resume_id got %0d want 1", irq_id); end
    irq_in = 6'h00;
    step(); step();
  endtask

  task automatic test_edge_vs_w1c();
    wr(2'd2, 32'h08);
    irq_in = 6'h08;
    addr = 2'd0; wdata = 32'h08; we = 1'b1;
    step();
    we = 1'b0;
    irq_in = 6'h00;
    addr = 2'd0; #1;
    checks++; if (rdata !== 32'h08) begin failures++; $display("FAIL edge_set_wins got %h want 08", rdata); end
    wr(2'd2, 32'h00);
    addr = 2'd0; #1;
    checks++; if (rdata !== 32'h00) begin failures++; $display("FAIL mode_change_clear got %h want 00", rdata); end
    step(); step();
  endtask

  task automatic test_eoi_and_ack();
    irq_in = 6'h04;
    step(); step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    irq_in = 6'h20;
    step(); step();
    checks++; if (hwint !== 6'h20) begin failures++; $display("FAIL eoiack_setup got %h want 20", hwint); end
    addr = 2'd3; wdata = 32'h0; we = 1'b1; int_ack = 1'b1;
    step();
    we = 1'b0; int_ack = 1'b0;
    addr = 2'd3; #1;
    checks++; if (rdata[5:0] !== 6'h20) begin failures++; $display("FAIL eoiack_isr got %h want 20", rdata[5:0]); end
    irq_in = 6'h00;
    wr(2'd3, 32'h0);
    step(); step();
  endtask

  task automatic test_ack_idle();
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL idle_hwint got %h want 00", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    addr = 2'd3; #1;
    checks++; if (rdata !== 32'h700) begin failures++; $display("FAIL idle_ack_isr got %h want 00000700", rdata); end
  endtask

  task automatic test_reset_mid();
    wr(2'd2, 32'h01);
    irq_in = 6'h10;
    step(); step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    addr = 2'd3; #1;
    checks++; if (rdata[5:0] !== 6'h10) begin failures++; $display("FAIL rmid_setup got %h want 10", rdata[5:0]); end
    reset = 1'b0; we = 1'b1; addr = 2'd1; wdata = 32'h3F; int_ack = 1'b1;
    step();
    reset = 1'b1; we = 1'b0; int_ack = 1'b0; irq_in = 6'h00;
    checks++; if (hwint !== 6'h00) begin failures++; $display("FAIL rmid_hwint got %h want 00", hwint); end
    checks++; if (irq_id !== 3'd7) begin failures++; $display("FAIL rmid_irq_id got %0d want 7", irq_id); end
    for (int r = 0; r < 3; r++) begin
      addr = 2'(r); #1;
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rmid_reg%0d got %h want 0", r, rdata); end
    end
    addr = 2'd3; #1;
    checks++; if (rdata !== 32'h700) begin failures++; $display("FAIL rmid_isr got %h want 00000700", rdata); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_nesting();
    test_edge_vs_w1c();
    test_eoi_and_ack();
    test_ack_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
